load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: validates a byte/half/word request, drives a registered-read
// byte-lane RAM manager, and returns an extended load result or fault flag.
module load_store_unit #(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [15:0] ld_count,
  output logic [15:0] st_count,
  output logic [15:0] fault_count
);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, CAPTURE, RESP} state_t;

  state_t      stateQ, stateD;
  logic        accept;
  logic        reqFault;
  logic [2:0]  nBytes;
  logic [32:0] endAddr;

  logic        reqWriteP0;
  logic [1:0]  reqSizeP0;
  logic        reqUnsignedP0;
  logic [31:0] reqAddrP0;
  logic [31:0] reqWdataP0;
  logic        reqFaultP0;
  logic [31:0] rdataP1;

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [31:0] extendLoad(input logic [31:0] raw,
                                             input logic [1:0]  size,
                                             input logic        uns);
    logic signed [7:0]  sByte;
    logic signed [15:0] sHalf;
    logic signed [31:0] wide;
    sByte = raw[7:0];
    sHalf = raw[15:0];
    case (size)
      2'b00:   wide = uns ? $signed({24'd0, raw[7:0]})  : 32'(sByte);
      2'b01:   wide = uns ? $signed({16'd0, raw[15:0]}) : 32'(sHalf);
      default: wide = $signed(raw);
    endcase
    return $unsigned(wide);
  endfunction

  assign req_ready = (stateQ == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // 33-bit end address so a request near 2^32 cannot wrap past the range check
  always_comb begin
    case (req_size)
      2'b00:   nBytes = 3'd1;
      2'b01:   nBytes = 3'd2;
      default: nBytes = 3'd4;
    endcase
    endAddr  = {1'b0, req_addr} + {30'd0, nBytes};
    reqFault = (req_size == 2'b11)
            || ((req_size == 2'b01) && req_addr[0])
            || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            || (endAddr > 33'(MEM_BYTES));
  end

  always_ff @(posedge clk) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (accept) stateD = reqFault ? RESP : (req_write ? STORE : LOAD);
      STORE:   stateD = RESP;
      LOAD:    stateD = CAPTURE;
      CAPTURE: stateD = RESP;
      RESP:    if (resp_ready) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Stage p0: request fields captured at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      reqWriteP0    <= req_write;
      reqSizeP0     <= req_size;
      reqUnsignedP0 <= req_unsigned;
      reqAddrP0     <= req_addr;
      reqWdataP0    <= req_wdata;
      reqFaultP0    <= reqFault;
    end
  end

  // Stage p1: RAM read data registered at the end of CAPTURE
  always_ff @(posedge clk) begin
    if (stateQ == CAPTURE) rdataP1 <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_count    <= 16'd0;
      st_count    <= 16'd0;
      fault_count <= 16'd0;
    end else if ((stateQ == RESP) && resp_ready) begin
      if (reqFaultP0)      fault_count <= satInc(fault_count);
      else if (reqWriteP0) st_count    <= satInc(st_count);
      else                 ld_count    <= satInc(ld_count);
    end
  end

  // Every output is forced quiet while rst is high, even mid-store
  always_comb begin
    resp_valid = (stateQ == RESP) && !rst;
    resp_fault = resp_valid && reqFaultP0;
    resp_rdata = (resp_valid && !reqFaultP0 && !reqWriteP0)
               ? extendLoad(rdataP1, reqSizeP0, reqUnsignedP0) : 32'd0;
    mem_addr   = ((stateQ != IDLE) && !rst) ? reqAddrP0 : 32'd0;
    mem_din    = ((stateQ == STORE) && !rst) ? reqWdataP0 : 32'd0;
    mem_we     = 4'b0000;
    if ((stateQ == STORE) && !rst) begin
      case (reqSizeP0)
        2'b00:   mem_we = 4'b0001;
        2'b01:   mem_we = 4'b0011;
        default: mem_we = 4'b1111;
      endcase
    end
  end

endmodule
